// File: rtl/irri_pkg.sv
// Shared types and helpers for the irrigation zone scheduler.
package irri_pkg;

  typedef enum logic [1:0] {
    StScan  = 2'd0,
    StOpen  = 2'd1,
    StPump  = 2'd2,
    StClose = 2'd3
  } state_e;

  localparam int unsigned DryThrDef = 51;
  localparam int unsigned WetThrDef = 153;

  // Round-robin successor of idx among n slots.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/irri_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr_i, modulo NReq.
module irri_rr_pick #(
  parameter int unsigned NReq = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [NReq-1:0] req_i,
  input  logic [IdxW-1:0] rr_ptr_i,
  output logic            valid_o,
  output logic [IdxW-1:0] index_o
);

  // Slot k positions after ptr, wrapped into 0..NReq-1 (ptr is always < NReq).
  function automatic logic [IdxW-1:0] slot(input logic [IdxW-1:0] ptr, input int unsigned k);
    logic [IdxW:0] sum;
    sum = {1'b0, ptr} + (IdxW+1)'(k);
    if (sum >= (IdxW+1)'(NReq)) begin
      sum = sum - (IdxW+1)'(NReq);
    end
    return sum[IdxW-1:0];
  endfunction

  // Scan outward from the pointer and keep the first hit.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    for (int unsigned k = 0; k < NReq; k++) begin
      if (!valid_o && req_i[slot(rr_ptr_i, k)]) begin
        valid_o = 1'b1;
        index_o = slot(rr_ptr_i, k);
      end
    end
  end

endmodule

// File: rtl/irri_zone_sched.sv
// Shares one pump across N_ZONES valve zones: round-robin grant of dry zones, then
// valve-lead / pump / valve-lag sequencing and a per-zone cooldown after each service.
module irri_zone_sched
  import irri_pkg::*;
#(
  parameter int unsigned N_ZONES     = 4,
  parameter int unsigned LVL_W       = 8,
  parameter int unsigned DRY_THR     = DryThrDef,
  parameter int unsigned WET_THR     = WetThrDef,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned VALVE_LEAD  = 4,
  parameter int unsigned PUMP_CYCLES = 1000,
  parameter int unsigned VALVE_LAG   = 4,
  parameter int unsigned COOL_CYCLES = 5000,
  localparam int unsigned IdxW       = $clog2(N_ZONES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_ZONES-1:0]       zone_mask,
  input  logic [N_ZONES*LVL_W-1:0] wtr_lvl,
  output logic                     pump_on,
  output logic [N_ZONES-1:0]       valve,
  output logic [IdxW-1:0]          active_zone,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]      active_zone_q, active_zone_d;
  logic [N_ZONES-1:0]   valve_q, valve_d;
  logic                 pump_on_q, pump_on_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;
  logic                 abort_run_q, abort_run_d;  // current grant was cut short by en/mask
  logic [CNT_W-1:0]     cool_q [N_ZONES];
  logic [CNT_W-1:0]     cool_d [N_ZONES];
  logic                 cool_load;

  logic [LVL_W-1:0]     lvl [N_ZONES];
  logic [N_ZONES-1:0]   req;
  logic                 pick_valid;
  logic [IdxW-1:0]      pick_idx;
  logic                 stop_run;
  logic                 wet;

  for (genvar g = 0; g < N_ZONES; g++) begin : g_zone
    assign lvl[g] = wtr_lvl[g*LVL_W +: LVL_W];
    assign req[g] = en & zone_mask[g] & (lvl[g] <= LVL_W'(DRY_THR)) & (cool_q[g] == '0);
  end

  assign stop_run = ~en | ~zone_mask[active_zone_q];
  assign wet      = lvl[active_zone_q] >= LVL_W'(WET_THR);

  irri_rr_pick #(
    .NReq (N_ZONES),
    .IdxW (IdxW)
  ) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .index_o  (pick_idx)
  );

  // Cooldown counters: free-running decrement, load on grant completion wins.
  always_comb begin
    for (int i = 0; i < N_ZONES; i++) begin
      cool_d[i] = (cool_q[i] != '0) ? cool_q[i] - CNT_W'(1) : cool_q[i];
      if (cool_load && (active_zone_q == IdxW'(i))) begin
        cool_d[i] = CNT_W'(COOL_CYCLES);
      end
    end
  end

  // Grant FSM next-state and registered-output next values.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_ptr_d      = rr_ptr_q;
    active_zone_d = active_zone_q;
    valve_d       = valve_q;
    pump_on_d     = pump_on_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    aborted_d     = 1'b0;
    abort_run_d   = abort_run_q;
    cool_load     = 1'b0;
    unique case (state_q)
      StScan: begin
        pump_on_d = 1'b0;
        valve_d   = '0;
        busy_d    = 1'b0;
        if (pick_valid) begin
          state_d       = StOpen;
          active_zone_d = pick_idx;
          valve_d       = N_ZONES'(1) << pick_idx;
          busy_d        = 1'b1;
          cnt_d         = '0;
          abort_run_d   = 1'b0;
        end
      end
      StOpen: begin
        if (stop_run) begin
          state_d     = StClose;
          cnt_d       = '0;
          pump_on_d   = 1'b0;
          abort_run_d = 1'b1;
        end else if (cnt_q == CNT_W'(VALVE_LEAD - 1)) begin
          state_d   = StPump;
          cnt_d     = '0;
          pump_on_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StPump: begin
        if (stop_run) begin
          state_d     = StClose;
          cnt_d       = '0;
          pump_on_d   = 1'b0;
          abort_run_d = 1'b1;
        end else if (wet || (cnt_q == CNT_W'(PUMP_CYCLES - 1))) begin
          state_d   = StClose;
          cnt_d     = '0;
          pump_on_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StClose: begin
        if (cnt_q == CNT_W'(VALVE_LAG - 1)) begin
          state_d   = StScan;
          cnt_d     = '0;
          valve_d   = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = abort_run_q;
          cool_load = 1'b1;
          rr_ptr_d  = IdxW'(rr_next(32'(active_zone_q), N_ZONES));
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = StScan;
        cnt_d     = '0;
        pump_on_d = 1'b0;
        valve_d   = '0;
        busy_d    = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops pump and valves without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StScan;
      cnt_q         <= '0;
      rr_ptr_q      <= '0;
      active_zone_q <= '0;
      valve_q       <= '0;
      pump_on_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      abort_run_q   <= 1'b0;
      for (int i = 0; i < N_ZONES; i++) begin
        cool_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rr_ptr_q      <= rr_ptr_d;
      active_zone_q <= active_zone_d;
      valve_q       <= valve_d;
      pump_on_q     <= pump_on_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      abort_run_q   <= abort_run_d;
      for (int i = 0; i < N_ZONES; i++) begin
        cool_q[i] <= cool_d[i];
      end
    end
  end

  assign pump_on     = pump_on_q;
  assign valve       = valve_q;
  assign active_zone = active_zone_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign aborted     = aborted_q;

endmodule
